// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result source, load size and FSM state encodings.
package wb_pkg;

   typedef enum logic [1:0] {
      ALU  = 2'b00,
      MEM  = 2'b01,
      LINK = 2'b10
   } wb_sel_e;

   typedef enum logic [1:0] {
      BYTE   = 2'b00,
      HALF   = 2'b01,
      WORD   = 2'b10,
      NATIVE = 2'b11
   } load_size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      DRAIN = 2'b10
   } wb_state_e;

   // Source code 11 is not a load, so anything other than MEM takes the ALU/LINK path.
   function automatic logic is_load(input logic [1:0] sel);
      return sel == MEM;
   endfunction

endpackage

// File: rtl/wb_stage_ctl_if.sv
// MEM-stage handshake and data-memory response bundle feeding the writeback stage.
interface wb_stage_ctl_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              mem_valid;
   logic              mem_ready;
   logic              mem_reg_write;
   logic [1:0]        mem_wb_sel;
   logic [1:0]        mem_load_size;
   logic              mem_load_unsigned;
   logic [REG_AW-1:0] mem_rd;
   logic [DATA_W-1:0] mem_alu_result;
   logic [DATA_W-1:0] mem_link_addr;
   logic [DATA_W-1:0] dmem_rdata;
   logic              dmem_rvalid;
   logic              wb_flush;

   modport master (
      output mem_valid, mem_reg_write, mem_wb_sel, mem_load_size, mem_load_unsigned,
             mem_rd, mem_alu_result, mem_link_addr, dmem_rdata, dmem_rvalid, wb_flush,
      input  mem_ready
   );

   modport slave (
      input  mem_valid, mem_reg_write, mem_wb_sel, mem_load_size, mem_load_unsigned,
             mem_rd, mem_alu_result, mem_link_addr, dmem_rdata, dmem_rvalid, wb_flush,
      output mem_ready
   );
endinterface

// File: rtl/wb_load_align.sv
// Extracts a byte/half/word/native lane from a little-endian load container and extends it.
module wb_load_align
   import wb_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int OB     = $clog2(DATA_W / 8)
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [OB-1:0]     offset,
   input  load_size_e        size,
   input  logic              load_unsigned,
   output logic [DATA_W-1:0] data,
   output logic              misalign
);

   logic [OB-1:0] half_off;
   logic [OB-1:0] word_off;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [31:0]   lane_w;

   // Misaligned halves and words still read the lane their aligned-down offset selects.
   always_comb begin
      half_off = offset & ~OB'(1);
      word_off = offset & ~OB'(3);
      lane_b   = 8'(rdata >> {offset, 3'b000});
      lane_h   = 16'(rdata >> {half_off, 3'b000});
      lane_w   = 32'(rdata >> {word_off, 3'b000});
      data     = '0;
      misalign = 1'b0;
      case (size)
         BYTE: begin
            if (load_unsigned) data = DATA_W'(lane_b);
            else               data = DATA_W'($signed(lane_b));
         end
         HALF: begin
            if (load_unsigned) data = DATA_W'(lane_h);
            else               data = DATA_W'($signed(lane_h));
            misalign = offset[0];
         end
         WORD: begin
            if (load_unsigned) data = DATA_W'(lane_w);
            else               data = DATA_W'($signed(lane_w));
            misalign = (offset & OB'(3)) != '0;
         end
         default: begin
            data     = rdata;
            misalign = offset != '0;
         end
      endcase
   end

endmodule

// File: rtl/wb_stage_ctl.sv
// Writeback stage: MEM/WB register, result select, load alignment and variable-latency load wait.
module wb_stage_ctl
   import wb_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   wb_stage_ctl_if.slave        bus,
   output logic                 wb_reg_write,
   output logic [REG_AW-1:0]    wb_rd,
   output logic [DATA_W-1:0]    wb_data,
   output logic                 wb_misalign,
   output logic                 wb_busy
);

   localparam int OB = $clog2(DATA_W / 8);

   typedef struct packed {
      logic              reg_write;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] data;
      logic              misalign;
   } commit_t;

   wb_state_e         state, state_next;
   logic              accept, load_done, alu_done, in_load;
   logic              p_reg_write, p_unsigned;
   logic [REG_AW-1:0] p_rd;
   load_size_e        p_size;
   logic [OB-1:0]     p_offset;
   logic [OB-1:0]     a_offset;
   load_size_e        a_size;
   logic              a_unsigned;
   logic [DATA_W-1:0] a_data;
   logic              a_misalign;
   logic              defer_valid, first_v, second_v;
   commit_t           defer, load_c, alu_c, first_c, second_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept && in_load && !bus.dmem_rvalid) state_next = WAIT;
         end
         WAIT: begin
            if (bus.wb_flush)         state_next = bus.dmem_rvalid ? IDLE : DRAIN;
            else if (bus.dmem_rvalid) state_next = (accept && in_load) ? WAIT : IDLE;
         end
         DRAIN: begin
            if (bus.dmem_rvalid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A response in WAIT belongs to the outstanding load, never to a transfer accepted alongside it.
   always_comb begin
      in_load       = is_load(bus.mem_wb_sel);
      bus.mem_ready = ((state == IDLE) || (state == WAIT && bus.dmem_rvalid)) && !bus.wb_flush;
      accept        = bus.mem_valid && bus.mem_ready;
      load_done     = (state == IDLE && accept && in_load && bus.dmem_rvalid) ||
                      (state == WAIT && bus.dmem_rvalid && !bus.wb_flush);
      alu_done      = accept && !in_load;
      wb_busy       = state != IDLE;
   end

   always_comb begin
      if (state == WAIT) begin
         a_offset   = p_offset;
         a_size     = p_size;
         a_unsigned = p_unsigned;
      end else begin
         a_offset   = bus.mem_alu_result[OB-1:0];
         a_size     = load_size_e'(bus.mem_load_size);
         a_unsigned = bus.mem_load_unsigned;
      end
   end

   wb_load_align #(.DATA_W(DATA_W)) u_align (
      .rdata         (bus.dmem_rdata),
      .offset        (a_offset),
      .size          (a_size),
      .load_unsigned (a_unsigned),
      .data          (a_data),
      .misalign      (a_misalign)
   );

   // Commits leave in order deferred, load, then ALU/LINK; the runner-up waits one cycle in defer.
   always_comb begin
      load_c.reg_write = (state == WAIT) ? p_reg_write : bus.mem_reg_write;
      load_c.rd        = (state == WAIT) ? p_rd : bus.mem_rd;
      load_c.data      = a_data;
      load_c.misalign  = a_misalign;
      alu_c.reg_write  = bus.mem_reg_write;
      alu_c.rd         = bus.mem_rd;
      alu_c.data       = (bus.mem_wb_sel == LINK) ? bus.mem_link_addr : bus.mem_alu_result;
      alu_c.misalign   = 1'b0;
      first_v  = 1'b0;
      second_v = 1'b0;
      first_c  = '0;
      second_c = '0;
      if (defer_valid) begin
         first_v = 1'b1;
         first_c = defer;
         if (load_done) begin
            second_v = 1'b1;
            second_c = load_c;
         end else if (alu_done) begin
            second_v = 1'b1;
            second_c = alu_c;
         end
      end else if (load_done) begin
         first_v = 1'b1;
         first_c = load_c;
         if (alu_done) begin
            second_v = 1'b1;
            second_c = alu_c;
         end
      end else if (alu_done) begin
         first_v = 1'b1;
         first_c = alu_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_reg_write  <= 1'b0;
         p_rd         <= '0;
         p_size       <= BYTE;
         p_unsigned   <= 1'b0;
         p_offset     <= '0;
         defer_valid  <= 1'b0;
         defer        <= '0;
         wb_reg_write <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         wb_misalign  <= 1'b0;
      end else begin
         if (accept) begin
            p_reg_write <= bus.mem_reg_write;
            p_rd        <= bus.mem_rd;
            p_size      <= load_size_e'(bus.mem_load_size);
            p_unsigned  <= bus.mem_load_unsigned;
            p_offset    <= bus.mem_alu_result[OB-1:0];
         end
         wb_reg_write <= first_v && first_c.reg_write && !first_c.misalign &&
                         !((ZERO_REG != 0) && (first_c.rd == '0));
         wb_misalign  <= first_v && first_c.misalign;
         if (first_v) begin
            wb_rd   <= first_c.rd;
            wb_data <= first_c.data;
         end
         defer_valid <= second_v;
         defer       <= second_c;
      end
   end

endmodule
